// File: rtl/dequant_zz_writer.sv
// Dequantizing writer: pairs each coefficient with its zigzag address, applies a
// position-dependent left shift and writes the block RAM. Optional macro DEQUANT_CLAMP_EN.
module dequant_zz_writer #(
    parameter int COEFF_W = 16
) (
    input  logic               Clock_50,
    input  logic               Reset,
    input  logic               start,
    input  logic               mode,
    input  logic               q_sel,
    input  logic               in_valid,
    input  logic [8:0]         in_data,
    output logic               in_ready,
    input  logic [7:0]         ZZ_address,
    output logic               ZZ_enable,
    output logic               ZZ_restart,
    output logic               wr_en,
    output logic [7:0]         wr_addr,
    output logic [COEFF_W-1:0] wr_data,
    output logic               busy,
    output logic               done
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_RESTART | one-cycle zigzag counter restart
    // S_RUN     | accepting coefficients
    // S_DONE    | one-cycle end-of-block pulse
    typedef enum logic [1:0] {S_IDLE, S_RESTART, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               q_sel_q, q_sel_d;
    logic [8:0]         count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               zz_restart_q, zz_restart_d;
    logic               wr_en_q, wr_en_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [COEFF_W-1:0] wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               handshake;
    logic [3:0]         ri, ci;
    logic [4:0]         pos_sum;
    logic [2:0]         shift_amt;
    logic [COEFF_W-1:0] ext, shifted, dq;
    logic [8:0]         count_last;

    assign handshake  = in_valid & in_ready_q;
    assign count_last = mode_q ? 9'd255 : 9'd63;

    always_comb begin
        if (mode_q) begin
            ri = ZZ_address[7:4];
            ci = ZZ_address[3:0];
        end else begin
            ri = {1'b0, ZZ_address[5:3]};
            ci = {1'b0, ZZ_address[2:0]};
        end
    end

    assign pos_sum = 5'(ri) + 5'(ci);

    // DC keeps a fixed shift of 3 in both tables; AC shifts grow with frequency.
    always_comb begin
        if (pos_sum == 5'd0)
            shift_amt = 3'd3;
        else if (pos_sum <= 5'd3)
            shift_amt = q_sel_q ? 3'd1 : ((pos_sum == 5'd1) ? 3'd2 : 3'd3);
        else if (pos_sum <= 5'd7)
            shift_amt = q_sel_q ? 3'd2 : 3'd4;
        else if (pos_sum <= 5'd11)
            shift_amt = q_sel_q ? 3'd3 : 3'd5;
        else
            shift_amt = q_sel_q ? 3'd4 : 3'd6;
    end

    assign ext     = {{(COEFF_W-9){in_data[8]}}, in_data};
    assign shifted = ext << shift_amt;

`ifdef DEQUANT_CLAMP_EN
    localparam logic signed [COEFF_W-1:0] CLAMP_HI = COEFF_W'(2047);
    localparam logic signed [COEFF_W-1:0] CLAMP_LO = COEFF_W'(-2048);

    always_comb begin
        if ($signed(shifted) > CLAMP_HI)
            dq = CLAMP_HI;
        else if ($signed(shifted) < CLAMP_LO)
            dq = CLAMP_LO;
        else
            dq = shifted;
    end
`else
    assign dq = shifted;
`endif

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        q_sel_d      = q_sel_q;
        count_d      = count_q;
        in_ready_d   = in_ready_q;
        zz_restart_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RESTART;
                    mode_d       = mode;
                    q_sel_d      = q_sel;
                    zz_restart_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            S_RESTART: begin
                state_d    = S_RUN;
                count_d    = 9'd0;
                in_ready_d = 1'b1;
            end
            S_RUN: begin
                if (handshake) begin
                    count_d   = count_q + 9'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ZZ_address;
                    wr_data_d = dq;
                    if (count_q == count_last) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            q_sel_q      <= 1'b0;
            count_q      <= 9'd0;
            in_ready_q   <= 1'b0;
            zz_restart_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            q_sel_q      <= q_sel_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            zz_restart_q <= zz_restart_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign ZZ_enable  = handshake;
    assign ZZ_restart = zz_restart_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dequant_zz_writer.sv
// Bench for dequant_zz_writer: table-driven block vectors plus directed corner sequences.
module tb_dequant_zz_writer;

    localparam int COEFF_W = 16;

`ifdef DEQUANT_CLAMP_EN
    localparam logic [15:0] BIG_P = 16'd2047;
    localparam logic [15:0] BIG_N = 16'hF800;
`else
    localparam logic [15:0] BIG_P = 16'd16320;
    localparam logic [15:0] BIG_N = 16'hC000;
`endif

    logic               Clock_50 = 1'b0;
    logic               Reset, start, mode, q_sel, in_valid;
    logic [8:0]         in_data;
    logic               in_ready;
    logic [7:0]         ZZ_address;
    logic               ZZ_enable, ZZ_restart, wr_en;
    logic [7:0]         wr_addr;
    logic [COEFF_W-1:0] wr_data;
    logic               busy, done;

    dequant_zz_writer #(.COEFF_W(COEFF_W)) dut (
        .Clock_50  (Clock_50),
        .Reset     (Reset),
        .start     (start),
        .mode      (mode),
        .q_sel     (q_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ZZ_address(ZZ_address),
        .ZZ_enable (ZZ_enable),
        .ZZ_restart(ZZ_restart),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clock_50 = ~Clock_50;

    // Zigzag counter model (transposed JPEG order: first move is down a row)
    logic [7:0] zz8 [64];
    logic [7:0] zz16[256];
    logic [7:0] zz_idx;
    logic       cur_mode;

    always @(posedge Clock_50 or posedge Reset) begin
        if (Reset)           zz_idx <= 8'd0;
        else if (ZZ_restart) zz_idx <= 8'd0;
        else if (ZZ_enable)  zz_idx <= zz_idx + 8'd1;
    end

    assign ZZ_address = cur_mode ? zz16[zz_idx] : zz8[zz_idx[5:0]];

    // Monitor: free-running totals, blocks take snapshots
    int          wtot = 0, ztot = 0, rtot = 0, dtot = 0, viol = 0, done_widx = -1;
    logic        prev_hs = 1'b0;
    logic [7:0]  wa[512];
    logic [15:0] wd[512];

    always @(negedge Clock_50) begin
        if (done) begin
            dtot++;
            done_widx = wtot;
            if (!wr_en) viol++;
        end
        if (wr_en) begin
            if (!prev_hs) viol++;
            wa[wtot % 512] = wr_addr;
            wd[wtot % 512] = wr_data;
            wtot++;
        end
        if (ZZ_enable) ztot++;
        if (ZZ_restart) rtot++;
        if (ZZ_enable !== (in_valid & in_ready)) viol++;
        prev_hs = ZZ_enable;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock_50);
        #1;
    endtask

    task automatic build_zz(input int n);
        int k, lo, hi;
        k = 0;
        for (int d = 0; d <= 2*n-2; d++) begin
            lo = (d - n + 1 < 0) ? 0 : d - n + 1;
            hi = (d < n - 1) ? d : n - 1;
            for (int j = 0; j <= hi - lo; j++) begin
                int r;
                r = (d % 2 == 1) ? lo + j : hi - j;
                if (n == 8) zz8[k]  = 8'((d - r) * 8 + r);
                else        zz16[k] = 8'((d - r) * 16 + r);
                k++;
            end
        end
    endtask

    task automatic run_block(input logic m, input logic qs, input logic [8:0] din,
                             input int spa, input logic [8:0] spd, input int gap,
                             input int stray, input string nm, output int w0);
        int z0, r0, d0, v0, cyc, n;
        n  = m ? 256 : 64;
        w0 = wtot; z0 = ztot; r0 = rtot; d0 = dtot; v0 = viol;
        cur_mode = m;
        mode = m; q_sel = qs; start = 1'b1;
        tick;
        start = 1'b0; mode = ~m; q_sel = ~qs;
        cyc = 0;
        while (dtot == d0 && cyc < 3000) begin
            in_valid = (int'($urandom_range(99)) >= gap);
            in_data  = (int'(ZZ_address) == spa) ? spd : din;
            start    = (cyc == stray);
            tick;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk({nm, " done_pulses"}, 32'(dtot - d0), 32'd1);
        chk({nm, " write_count"}, 32'(wtot - w0), 32'(n));
        chk({nm, " zz_enable_count"}, 32'(ztot - z0), 32'(n));
        chk({nm, " restart_pulses"}, 32'(rtot - r0), 32'd1);
        chk({nm, " done_on_last_write"}, 32'(done_widx - w0), 32'(n - 1));
        chk({nm, " protocol_violations"}, 32'(viol - v0), 32'd0);
        chk({nm, " busy_after_done"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic        m;
        logic        qs;
        logic [8:0]  din;
        int          spa;
        logic [8:0]  spd;
        int          widx;
        logic [7:0]  ea;
        logic [15:0] ed;
    } vec_t;

    vec_t vt[14];

    initial begin
        int w0, cnt, cyc;
        bit seen[256];

        vt[0]  = '{1'b0, 1'b0, 9'd1,   -1,   9'd0,   0,   8'h00, 16'd8};
        vt[1]  = '{1'b0, 1'b0, 9'd1,   -1,   9'd0,   1,   8'h08, 16'd4};
        vt[2]  = '{1'b0, 1'b0, 9'd1,   -1,   9'd0,   2,   8'h01, 16'd4};
        vt[3]  = '{1'b0, 1'b0, 9'd1,   -1,   9'd0,   3,   8'h02, 16'd8};
        vt[4]  = '{1'b0, 1'b0, 9'd1,   -1,   9'd0,   63,  8'h3F, 16'd64};
        vt[5]  = '{1'b0, 1'b1, 9'd1,   -1,   9'd0,   0,   8'h00, 16'd8};
        vt[6]  = '{1'b0, 1'b1, 9'd1,   -1,   9'd0,   1,   8'h08, 16'd2};
        vt[7]  = '{1'b0, 1'b0, 9'd1,   8'h3F, 9'd255, 63, 8'h3F, BIG_P};
        vt[8]  = '{1'b0, 1'b0, 9'd1,   8'h3F, 9'h100, 63, 8'h3F, BIG_N};
        vt[9]  = '{1'b1, 1'b0, 9'h1FF, -1,   9'd0,   255, 8'hFF, 16'hFFC0};
        vt[10] = '{1'b1, 1'b1, 9'd5,   -1,   9'd0,   3,   8'h02, 16'd10};
        vt[11] = '{1'b0, 1'b1, 9'h1FD, -1,   9'd0,   4,   8'h09, 16'hFFFA};
        vt[12] = '{1'b0, 1'b0, 9'd1,   8'h24, 9'd100, 39, 8'h24, 16'h0C80};
        vt[13] = '{1'b0, 1'b0, 9'd7,   -1,   9'd0,   10,  8'h04, 16'h0070};

        build_zz(8);
        build_zz(16);
        cur_mode = 1'b0;
        Reset = 1'b1; start = 1'b0; mode = 1'b0; q_sel = 1'b0;
        in_valid = 1'b0; in_data = 9'd0;
        #22;
        chk("reset_outputs", 32'({in_ready, ZZ_enable, ZZ_restart, wr_en, busy, done, wr_addr, wr_data}), 32'd0);
        tick;
        Reset = 1'b0;
        tick;

        for (int i = 0; i < 14; i++) begin
            run_block(vt[i].m, vt[i].qs, vt[i].din, vt[i].spa, vt[i].spd, 0, -1,
                      $sformatf("vec%0d", i), w0);
            chk($sformatf("vec%0d addr", i), 32'(wa[(w0 + vt[i].widx) % 512]), 32'(vt[i].ea));
            chk($sformatf("vec%0d data", i), 32'(wd[(w0 + vt[i].widx) % 512]), 32'(vt[i].ed));
            if (i == 0) begin
                foreach (seen[k]) seen[k] = 1'b0;
                cnt = 0;
                for (int k = 0; k < 64; k++) begin
                    if (!seen[wa[(w0 + k) % 512]]) cnt++;
                    seen[wa[(w0 + k) % 512]] = 1'b1;
                end
                chk("distinct_addresses_8x8", 32'(cnt), 32'd64);
            end
        end

        // 16x16, Q1, -1 everywhere, with random valid gaps
        run_block(1'b1, 1'b1, 9'h1FF, -1, 9'd0, 30, -1, "gaps16", w0);
        chk("gaps16 last_addr", 32'(wa[(w0 + 255) % 512]), 32'h0000_00FF);
        chk("gaps16 last_data", 32'(wd[(w0 + 255) % 512]), 32'h0000_FFF0);

        // Stray start mid-block, then a start right at N+2
        run_block(1'b0, 1'b0, 9'd1, -1, 9'd0, 0, 20, "stray_start", w0);
        run_block(1'b0, 1'b0, 9'd1, -1, 9'd0, 0, -1, "back_to_back", w0);
        chk("back_to_back first_addr", 32'(wa[w0 % 512]), 32'd0);

        // Start then starve input for 100 cycles
        w0 = wtot;
        cur_mode = 1'b0; mode = 1'b0; q_sel = 1'b0; start = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b0;
        repeat (101) tick;
        chk("stall writes", 32'(wtot - w0), 32'd0);
        chk("stall busy", {31'd0, busy}, 32'd1);
        chk("stall in_ready", {31'd0, in_ready}, 32'd1);
        chk("stall zz_enable", {31'd0, ZZ_enable}, 32'd0);
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        tick;

        // Reset asserted mid-RUN after 10 writes
        w0 = wtot;
        cur_mode = 1'b0; mode = 1'b0; q_sel = 1'b0; start = 1'b1;
        tick;
        start = 1'b0; in_valid = 1'b1; in_data = 9'd1;
        cyc = 0;
        while (wtot - w0 < 10 && cyc < 200) begin
            tick;
            cyc++;
        end
        chk("midreset writes_before", {31'd0, (wtot - w0 >= 10)}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("midreset async_outputs", 32'({in_ready, ZZ_enable, ZZ_restart, wr_en, busy, done, wr_addr, wr_data}), 32'd0);
        tick;
        Reset = 1'b0; in_valid = 1'b0;
        tick;
        run_block(1'b0, 1'b0, 9'd1, -1, 9'd0, 0, -1, "after_reset", w0);
        chk("after_reset first_addr", 32'(wa[w0 % 512]), 32'd0);
        chk("after_reset first_data", 32'(wd[w0 % 512]), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dequant_zz_writer.md
# dequant_zz_writer

Downstream consumer of the zigzag address counter in the decode path. It accepts a stream of quantized coefficients, pairs each one with the current zigzag address, and dequantizes it by a position-dependent left shift. It then writes the result into the coefficient block RAM that feeds the IDCT. It also drives the counter's enable and restart, and frames each 8x8 or 16x16 block with busy/done.

## Interface
- COEFF_W, default 16: width of `wr_data`, in bits; must be ≥ 16.
- Clock_50  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a block; sampled only in IDLE.
- mode  in  1  block size: 0 = 8x8 (64 coefficients), 1 = 16x16 (256); latched at start.
- q_sel  in  1  quantization table select, Q0/Q1; latched at start.
- in_valid  in  1  `in_data` valid.
- in_data  in  9  signed quantized coefficient.
- in_ready  out  1  block accepts a coefficient this cycle.
- ZZ_address  in  8  current zigzag position: {ri,ci} in 16x16 mode, {2'b0,ri[2:0],ci[2:0]} in 8x8 mode.
- ZZ_enable  out  1  advances the zigzag counter; high exactly on each accepted handshake.
- ZZ_restart  out  1  one-cycle pulse that reinitializes the counter to position (0,0); OR'ed with system reset at top level.
- wr_en  out  1  block RAM write strobe.
- wr_addr  out  8  block RAM address.
- wr_data  out  COEFF_W  signed dequantized coefficient.
- busy  out  1  a block is in progress.
- done  out  1  single-cycle pulse, coincident with the final write.

## Operation
- FSM states: IDLE, RESTART, RUN, DONE.
- IDLE: `start` moves the FSM to RESTART and latches `mode` and `q_sel`.
- RESTART: lasts one cycle. `ZZ_restart`=1, `in_ready`=0, count cleared. Next state is RUN.
- RUN: `in_ready`=1. A handshake is `in_valid` & `in_ready`. On each handshake:
  - `ZZ_enable`=1 in the same cycle.
  - `ZZ_address`, `in_data`, and the computed shift are captured.
  - The 9-bit count increments.
- RUN to DONE: on the handshake with count = 63 (8x8) or 255 (16x16).
- DONE: lasts one cycle. `done`=1, then the FSM returns to IDLE.
- Position decode:
  - ri = `ZZ_address`[7:4], ci = `ZZ_address`[3:0] in 16x16 mode.
  - ri = `ZZ_address`[5:3], ci = `ZZ_address`[2:0] in 8x8 mode.
  - s = ri + ci, 5 bits, 0..30.
- Shift table, indexed by s:
  - Q0: s=0 → 3, s=1 → 2, s=2–3 → 3, s=4–7 → 4, s=8–11 → 5, s≥12 → 6.
  - Q1: s=0 → 3, s=1 → 1, s=2–3 → 1, s=4–7 → 2, s=8–11 → 3, s≥12 → 4.
- Arithmetic: `wr_data` = sign_extend(`in_data`) << shift.
  - Maximum magnitude is 256·64 = 16384, which needs 16 bits, so there is no overflow at COEFF_W ≥ 16.
- `wr_addr` = the captured `ZZ_address` unchanged.
- `start` while busy is ignored and has no lasting effect.
- `in_valid` outside RUN is ignored; no handshake occurs.

## Timing
- Reset values: `in_ready`, `ZZ_enable`, `ZZ_restart`, `wr_en`, `busy`, `done` = 0; `wr_addr`=0; `wr_data`=0; state = IDLE.
- Reset mid-block: immediate return to IDLE with the reset values above. The partially written block is abandoned, and the counter is reinitialized by the system reset.
- `start` sampled high in IDLE at cycle T:
  - T+1: RESTART; `busy`=1 and `ZZ_restart`=1.
  - T+2: RUN; `ZZ_address` = 0 is guaranteed.
- Write latency is 1 cycle: a handshake at cycle N gives `wr_en`=1 at N+1 with that handshake's address and data.
  - `wr_en` is never high except following a handshake.
- Backpressure: `in_valid` gaps in RUN produce no `ZZ_enable` and no `wr_en`; the count and `ZZ_address` hold.
- Final handshake at cycle N:
  - N+1: DONE; `done`=1, `wr_en`=1, `busy`=1.
  - N+2: IDLE; `busy`=0.
  - A new `start` is accepted from N+2 onward.
- Minimum block period with no gaps: 64+3 cycles (8x8), 256+3 cycles (16x16).

## Configuration
- DEQUANT_CLAMP_EN defined:
  - `wr_data` is saturated to the IDCT input range of signed 12 bits, [-2048, 2047], before registering.
  - The output is sign-extended to COEFF_W.
- DEQUANT_CLAMP_EN undefined: `wr_data` is the full unsaturated shifted value.
- Latency is identical with and without the macro.

## Test plan
- 8x8, Q0, `in_data`=1 for all, no gaps:
  - Writes 0–3 are (addr, data) = (0x00, 8), (0x08, 4), (0x01, 4), (0x02, 8).
  - Exactly 64 `wr_en` pulses with 64 distinct addresses.
  - `done` coincides with write 64, at address 0x3F, data 64.
- 16x16, Q1, `in_data`=-1 for all, random `in_valid` gaps:
  - 256 writes in total.
  - Last write is addr 0xFF, data 0xFFF0 (-16).
  - Each `ZZ_enable` count equals the `wr_en` count; `ZZ_address` holds across gaps.
- 8x8, Q0, `in_data`=255 at the position with s=14 (addr 0x3F), 1 elsewhere:
  - DEQUANT_CLAMP_EN defined: that write's data = 2047.
  - Undefined: that write's data = 16320.
  - Repeat with -256: data = -2048 (clamped) or -16384 (unclamped).
- `start` pulsed at cycle 20 of an 8x8 block: ignored; block completes normally, and a `start` at N+2 begins a new block.
- `Reset` asserted mid-RUN after 10 writes:
  - All outputs are 0 asynchronously.
  - A following `start` gives `ZZ_restart` and a first write at address 0x00.
- `start` then `in_valid` held low for 100 cycles: no writes, `busy`=1, `in_ready`=1, state remains RUN.
